// File: rtl/l2_noc_tx.sv
// L2 NoC transmit serialiser: round-robin between req-out and rsp-out, packets emitted as HEAD/ADDR/DATA flits.
// Latency: HEAD flit valid one cycle after accept, then one flit per cycle under continuous noc_ready.
// Backpressure: flit held stable while noc_ready is low; sources accepted only in IDLE. Optional stats: L2_NOC_TX_STATS_EN.
module l2_noc_tx #(
  parameter int          ADDR_W        = 32,
  parameter int          OFF_W         = 4,
  parameter int          WORD_W        = 64,
  parameter int          LINE_WORDS    = 2,
  parameter int          MSG_W         = 5,
  parameter int          TILE_W        = 8,
  parameter logic [31:0] REQ_DATA_MASK = 32'h8,
  parameter logic [31:0] RSP_DATA_MASK = 32'h3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TILE_W-1:0]            local_tile,
  input  logic [TILE_W-1:0]            home_tile,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [MSG_W-1:0]             req_msg,
  input  logic [1:0]                   req_hprot,
  input  logic [ADDR_W-OFF_W-1:0]      req_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] req_line,
  input  logic                         rsp_valid,
  output logic                         rsp_ready,
  input  logic [MSG_W-1:0]             rsp_msg,
  input  logic                         rsp_to_req,
  input  logic [TILE_W-1:0]            rsp_req_id,
  input  logic [ADDR_W-OFF_W-1:0]      rsp_addr,
  input  logic [WORD_W*LINE_WORDS-1:0] rsp_line,
  output logic                         noc_valid,
  input  logic                         noc_ready,
  output logic [2+WORD_W-1:0]          noc_flit
`ifdef L2_NOC_TX_STATS_EN
  ,
  output logic [31:0]                  stats_req_pkts,
  output logic [31:0]                  stats_rsp_pkts,
  output logic [31:0]                  stats_stall_cycles
`endif
);

  localparam int LA_W   = ADDR_W - OFF_W;
  localparam int LINE_W = WORD_W * LINE_WORDS;
  localparam int FLIT_W = 2 + WORD_W;
  localparam int CNT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);

  localparam logic [1:0] PRE_HEAD = 2'b10;
  localparam logic [1:0] PRE_BODY = 2'b00;
  localparam logic [1:0] PRE_TAIL = 2'b01;

  typedef enum logic [1:0] {IDLE, HEAD, ADDR, DATA} state_t;

  state_t            state;
  logic              rr_ptr;        // 0: request source has priority, 1: response source
  logic              pkt_has_data;
  logic [LA_W-1:0]   pkt_addr;
  logic [LINE_W-1:0] pkt_line;
  logic [CNT_W-1:0]  word_cnt;

  logic              idle;
  logic              req_acc;
  logic              rsp_acc;
  logic              flit_done;
  logic [TILE_W-1:0] acc_dst;
  logic [MSG_W-1:0]  acc_msg;
  logic [LA_W-1:0]   acc_addr;
  logic [LINE_W-1:0] acc_line;
  logic              acc_has_data;

  // hprot travels alongside the message but is not carried in any flit
  logic unused_hprot;
  assign unused_hprot = ^req_hprot;

  function automatic logic [WORD_W-1:0] head_payload(input logic [TILE_W-1:0] src,
                                                     input logic [TILE_W-1:0] dst,
                                                     input logic [MSG_W-1:0]  msg);
    logic [WORD_W-1:0] p;
    p = '0;
    p[WORD_W-1 -: 2*TILE_W+MSG_W] = {src, dst, msg};
    return p;
  endfunction

  function automatic logic [WORD_W-1:0] addr_payload(input logic [LA_W-1:0] la);
    logic [WORD_W-1:0] p;
    p = '0;
    p[ADDR_W-1:0] = {la, {OFF_W{1'b0}}};
    return p;
  endfunction

  // Readies are combinational and only ever high while idle and out of reset
  assign idle      = (state == IDLE) & rst;
  assign rsp_ready = idle & rsp_valid & (!req_valid | rr_ptr);
  assign req_ready = idle & req_valid & !rsp_ready;
  assign req_acc   = req_valid & req_ready;
  assign rsp_acc   = rsp_valid & rsp_ready;
  assign flit_done = noc_valid & noc_ready;

  // Mux the granted source's message fields for capture
  always_comb begin
    acc_msg      = req_msg;
    acc_dst      = home_tile;
    acc_addr     = req_addr;
    acc_line     = req_line;
    acc_has_data = REQ_DATA_MASK[req_msg];
    if (rsp_acc) begin
      acc_msg      = rsp_msg;
      acc_dst      = rsp_to_req ? rsp_req_id : home_tile;
      acc_addr     = rsp_addr;
      acc_line     = rsp_line;
      acc_has_data = RSP_DATA_MASK[rsp_msg];
    end
  end

  // Packet FSM: the next flit is registered on the same edge the current one completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      pkt_has_data <= 1'b0;
      pkt_addr     <= '0;
      pkt_line     <= '0;
      word_cnt     <= '0;
      noc_valid    <= 1'b0;
      noc_flit     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_acc || rsp_acc) begin
            pkt_has_data <= acc_has_data;
            pkt_addr     <= acc_addr;
            pkt_line     <= acc_line;
            rr_ptr       <= req_acc;
            noc_valid    <= 1'b1;
            noc_flit     <= {PRE_HEAD, head_payload(local_tile, acc_dst, acc_msg)};
            state        <= HEAD;
          end
        end
        HEAD: begin
          if (flit_done) begin
            noc_flit <= {(pkt_has_data ? PRE_BODY : PRE_TAIL), addr_payload(pkt_addr)};
            state    <= ADDR;
          end
        end
        ADDR: begin
          if (flit_done) begin
            if (pkt_has_data) begin
              word_cnt <= '0;
              noc_flit <= {((LINE_WORDS == 1) ? PRE_TAIL : PRE_BODY), pkt_line[WORD_W-1:0]};
              state    <= DATA;
            end else begin
              noc_valid <= 1'b0;
              noc_flit  <= '0;
              state     <= IDLE;
            end
          end
        end
        DATA: begin
          if (flit_done) begin
            if (word_cnt == LAST_WORD) begin
              word_cnt  <= '0;
              noc_valid <= 1'b0;
              noc_flit  <= '0;
              state     <= IDLE;
            end else begin
              word_cnt <= word_cnt + 1'b1;
              noc_flit <= {(((word_cnt + 1'b1) == LAST_WORD) ? PRE_TAIL : PRE_BODY),
                           pkt_line[(word_cnt + 1'b1)*WORD_W +: WORD_W]};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L2_NOC_TX_STATS_EN
  logic        pkt_is_rsp;
  logic [31:0] req_pkt_cnt;
  logic [31:0] rsp_pkt_cnt;
  logic [31:0] stall_cnt;
  logic        tail_done;

  assign tail_done          = flit_done & (noc_flit[FLIT_W-1 -: 2] == PRE_TAIL);
  assign stats_req_pkts     = req_pkt_cnt;
  assign stats_rsp_pkts     = rsp_pkt_cnt;
  assign stats_stall_cycles = stall_cnt;

  // Per-source packet counts on tail handshake, stall count on held flits; all wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_is_rsp  <= 1'b0;
      req_pkt_cnt <= '0;
      rsp_pkt_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (rsp_acc)      pkt_is_rsp <= 1'b1;
      else if (req_acc) pkt_is_rsp <= 1'b0;
      if (tail_done) begin
        if (pkt_is_rsp) rsp_pkt_cnt <= rsp_pkt_cnt + 32'd1;
        else            req_pkt_cnt <= req_pkt_cnt + 32'd1;
      end
      if (noc_valid && !noc_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_noc_tx.sv
// Bench for l2_noc_tx: randomized and directed traffic checked against a packet-level reference model.
module tb_l2_noc_tx;

  localparam logic [7:0] LOCAL = 8'h3C;
  localparam logic [7:0] HOME  = 8'hA7;

  typedef struct {
    logic [4:0]   msg;
    logic [1:0]   hprot;
    logic         to_req;
    logic [7:0]   req_id;
    logic [27:0]  addr;
    logic [127:0] line;
  } msg_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   local_tile = LOCAL;
  logic [7:0]   home_tile  = HOME;
  logic         req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]   req_msg, rsp_msg;
  logic [1:0]   req_hprot;
  logic [27:0]  req_addr, rsp_addr;
  logic [127:0] req_line, rsp_line;
  logic         rsp_to_req;
  logic [7:0]   rsp_req_id;
  logic         noc_valid, noc_ready;
  logic [65:0]  noc_flit;
`ifdef L2_NOC_TX_STATS_EN
  logic [31:0]  stats_req_pkts, stats_rsp_pkts, stats_stall_cycles;
`endif

  l2_noc_tx dut (
    .clk(clk), .rst(rst), .local_tile(local_tile), .home_tile(home_tile),
    .req_valid(req_valid), .req_ready(req_ready), .req_msg(req_msg), .req_hprot(req_hprot),
    .req_addr(req_addr), .req_line(req_line),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_msg(rsp_msg), .rsp_to_req(rsp_to_req),
    .rsp_req_id(rsp_req_id), .rsp_addr(rsp_addr), .rsp_line(rsp_line),
    .noc_valid(noc_valid), .noc_ready(noc_ready), .noc_flit(noc_flit)
`ifdef L2_NOC_TX_STATS_EN
    , .stats_req_pkts(stats_req_pkts), .stats_rsp_pkts(stats_rsp_pkts),
    .stats_stall_cycles(stats_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  msg_t        reqq[$];
  msg_t        rspq[$];
  logic [65:0] exp_q[$];
  logic [65:0] got_q[$];
  int          got_cyc[$];
  int          acc_cyc[$];
  bit          acc_src[$];
  bit          mrr = 1'b0;          // model: 1 means response source has priority
  int          m_req = 0, m_rsp = 0, m_stall = 0;

  function automatic msg_t mk(input logic [4:0] msg, input logic to_req, input logic [7:0] id,
                              input logic [27:0] addr, input logic [127:0] line);
    msg_t m;
    m.msg = msg; m.hprot = 2'(msg); m.to_req = to_req; m.req_id = id; m.addr = addr; m.line = line;
    return m;
  endfunction

  function automatic msg_t rand_msg();
    return mk(5'($urandom), 1'($urandom), 8'($urandom), 28'($urandom),
              {$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Reference: expand one message into its flit sequence
  function automatic void add_pkt(input bit is_rsp, input msg_t m);
    logic [7:0]  dst;
    logic [31:0] mask;
    bit          has;
    dst  = (is_rsp && m.to_req) ? m.req_id : HOME;
    mask = is_rsp ? 32'h3 : 32'h8;
    has  = mask[m.msg];
    exp_q.push_back({2'b10, LOCAL, dst, m.msg, 43'd0});
    exp_q.push_back({(has ? 2'b00 : 2'b01), 32'd0, m.addr, 4'd0});
    if (has) begin
      exp_q.push_back({2'b00, m.line[63:0]});
      exp_q.push_back({2'b01, m.line[127:64]});
    end
    if (is_rsp) m_rsp++; else m_req++;
  endfunction

  task automatic drive_idle();
    req_valid = 0; rsp_valid = 0; req_msg = 0; rsp_msg = 0; req_hprot = 0;
    req_addr = 0; rsp_addr = 0; req_line = 0; rsp_line = 0; rsp_to_req = 0; rsp_req_id = 0;
  endtask

  // Drive queued messages, collect flits, then compare against the predicted stream
  task automatic run_traffic(input int ready_pct, input int stall_idx, input int stall_len,
                             input int budget);
    msg_t        rq[$];
    msg_t        sq[$];
    bit          pick_rsp;
    int          cyc;
    int          stall_left;
    logic [65:0] held;
    bit          held_v;
    rq = reqq; sq = rspq;
    while (rq.size() > 0 || sq.size() > 0) begin
      if (rq.size() > 0 && sq.size() > 0) pick_rsp = mrr;
      else pick_rsp = (sq.size() > 0);
      if (pick_rsp) begin add_pkt(1, sq[0]); sq.pop_front(); end
      else begin add_pkt(0, rq[0]); rq.pop_front(); end
      mrr = !pick_rsp;
    end
    got_q.delete(); got_cyc.delete(); acc_cyc.delete(); acc_src.delete();
    cyc = 0; stall_left = stall_len; held = '0; held_v = 0;
    while ((reqq.size() > 0 || rspq.size() > 0 || got_q.size() < exp_q.size()) && cyc < budget) begin
      @(negedge clk);
      drive_idle();
      if (reqq.size() > 0) begin
        req_valid = 1; req_msg = reqq[0].msg; req_hprot = reqq[0].hprot;
        req_addr = reqq[0].addr; req_line = reqq[0].line;
      end
      if (rspq.size() > 0) begin
        rsp_valid = 1; rsp_msg = rspq[0].msg; rsp_to_req = rspq[0].to_req;
        rsp_req_id = rspq[0].req_id; rsp_addr = rspq[0].addr; rsp_line = rspq[0].line;
      end
      if (stall_left > 0 && got_q.size() == stall_idx && noc_valid) begin
        noc_ready = 0;
        stall_left--;
        if (held_v) begin
          vectors++;
          if (noc_flit !== held) begin
            miscompares++;
            $display("FAIL stall_hold: flit %h, required held %h", noc_flit, held);
          end
        end
        held = noc_flit; held_v = 1;
      end else begin
        noc_ready = ($urandom_range(99) < 32'(ready_pct));
      end
      #1;
      vectors++;
      if (req_ready && rsp_ready) begin
        miscompares++;
        $display("FAIL dual_grant: req_ready=%b rsp_ready=%b, required not both", req_ready, rsp_ready);
      end
      if (req_valid && req_ready) begin reqq.pop_front(); acc_cyc.push_back(cyc); acc_src.push_back(0); end
      if (rsp_valid && rsp_ready) begin rspq.pop_front(); acc_cyc.push_back(cyc); acc_src.push_back(1); end
      if (noc_valid && noc_ready) begin got_q.push_back(noc_flit); got_cyc.push_back(cyc); end
      if (noc_valid && !noc_ready) m_stall++;
      cyc++;
    end
    if (cyc >= budget) begin
      miscompares++;
      $display("FAIL timeout: %0d flits after %0d cycles, required %0d", got_q.size(), cyc, exp_q.size());
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL flit_count: got %0d, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL flit[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    exp_q.delete();
    @(negedge clk);
    drive_idle();
    noc_ready = 1;
  endtask

  task automatic test_reset();
    rst = 0; drive_idle(); noc_ready = 0;
    req_valid = 1; rsp_valid = 1;
    #23;
    vectors++;
    if (noc_valid !== 1'b0 || noc_flit !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_out: valid=%b flit=%h, required 0/0", noc_valid, noc_flit);
    end
    vectors++;
    if (req_ready !== 1'b0 || rsp_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: req=%b rsp=%b, required 0/0", req_ready, rsp_ready);
    end
    @(negedge clk);
    drive_idle();
    noc_ready = 1;
    rst = 1;
    mrr = 0; m_req = 0; m_rsp = 0; m_stall = 0;
  endtask

  task automatic test_gets();
    reqq.push_back(mk(5'd1, 0, 8'd0, 28'h0ABCDEF, '0));
    run_traffic(100, -1, 0, 100);
    if (got_q.size() == 2 && acc_cyc.size() == 1) begin
      vectors++;
      if (got_cyc[0] != acc_cyc[0] + 1 || got_cyc[1] != got_cyc[0] + 1) begin
        miscompares++;
        $display("FAIL gets_timing: acc %0d head %0d tail %0d, required consecutive", acc_cyc[0], got_cyc[0], got_cyc[1]);
      end
      vectors++;
      if (got_q[0][65:64] !== 2'b10 || got_q[0][55:48] !== HOME) begin
        miscompares++;
        $display("FAIL gets_head: %h, required pre 10 dst %h", got_q[0], HOME);
      end
      vectors++;
      if (got_q[1] !== {2'b01, 64'h0ABCDEF0}) begin
        miscompares++;
        $display("FAIL gets_tail: %h, required %h", got_q[1], {2'b01, 64'h0ABCDEF0});
      end
    end
  endtask

  task automatic test_edata();
    rspq.push_back(mk(5'd1, 1, 8'd5, 28'h1234567, {64'hCAFE_0000_0000_0001, 64'hBEEF_0000_0000_0000}));
    run_traffic(100, -1, 0, 100);
    if (got_q.size() == 4) begin
      vectors++;
      if (got_q[0][55:48] !== 8'd5) begin
        miscompares++;
        $display("FAIL edata_dst: %h, required 05", got_q[0][55:48]);
      end
      vectors++;
      if (got_q[2] !== {2'b00, 64'hBEEF_0000_0000_0000} || got_q[3] !== {2'b01, 64'hCAFE_0000_0000_0001}) begin
        miscompares++;
        $display("FAIL edata_words: %h %h, required W0 body then W1 tail", got_q[2], got_q[3]);
      end
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 2; i++) begin
      reqq.push_back(mk(5'd1, 0, 8'd0, 28'(32'h100 + i), '0));
      rspq.push_back(mk(5'd2, 1, 8'(i), 28'(32'h200 + i), '0));
    end
    run_traffic(100, -1, 0, 200);
    vectors++;
    if (acc_src.size() != 4 || acc_src[0] != 0 || acc_src[1] != 1 || acc_src[2] != 0 || acc_src[3] != 1) begin
      miscompares++;
      $display("FAIL alternate: %0d grants, required REQ,RSP,REQ,RSP", acc_src.size());
    end
  endtask

  task automatic test_back_to_back();
    reqq.push_back(mk(5'd1, 0, 8'd0, 28'h0000AAA, '0));
    reqq.push_back(mk(5'd2, 0, 8'd0, 28'h0000BBB, '0));
    run_traffic(100, -1, 0, 100);
    if (got_cyc.size() == 4) begin
      vectors++;
      if (got_cyc[2] != got_cyc[1] + 2) begin
        miscompares++;
        $display("FAIL b2b_gap: tail %0d next head %0d, required gap of 2", got_cyc[1], got_cyc[2]);
      end
    end
  endtask

  task automatic test_stall();
`ifdef L2_NOC_TX_STATS_EN
    logic [31:0] s0;
    s0 = stats_stall_cycles;
`endif
    reqq.push_back(mk(5'd3, 0, 8'd0, 28'h0FEDCBA, {$urandom, $urandom, $urandom, $urandom}));
    run_traffic(100, 2, 3, 100);
    if (got_cyc.size() == 4) begin
      vectors++;
      if (got_cyc[2] != got_cyc[1] + 4) begin
        miscompares++;
        $display("FAIL stall_timing: addr %0d data %0d, required 4 cycles apart", got_cyc[1], got_cyc[2]);
      end
    end
`ifdef L2_NOC_TX_STATS_EN
    vectors++;
    if (stats_stall_cycles - s0 !== 32'd3) begin
      miscompares++;
      $display("FAIL stall_stat: delta %0d, required 3", stats_stall_cycles - s0);
    end
`endif
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      int nq, ns;
      nq = $urandom_range(6); ns = $urandom_range(6);
      for (int i = 0; i < nq; i++) reqq.push_back(rand_msg());
      for (int i = 0; i < ns; i++) rspq.push_back(rand_msg());
      run_traffic(60, -1, 0, 2000);
    end
  endtask

  task automatic test_stats();
`ifdef L2_NOC_TX_STATS_EN
    vectors++;
    if (stats_req_pkts !== 32'(m_req) || stats_rsp_pkts !== 32'(m_rsp) || stats_stall_cycles !== 32'(m_stall)) begin
      miscompares++;
      $display("FAIL stats: req %0d rsp %0d stall %0d, required %0d %0d %0d",
               stats_req_pkts, stats_rsp_pkts, stats_stall_cycles, m_req, m_rsp, m_stall);
    end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1; req_msg = 5'd1; req_addr = 28'h0000777; noc_ready = 1;
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    #1;
    vectors++;
    if (noc_valid !== 1'b1 || noc_flit[65:64] !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_addr: valid=%b pre=%b, required 1/01", noc_valid, noc_flit[65:64]);
    end
    rst = 0;
    #1;
    vectors++;
    if (noc_valid !== 1'b0 || noc_flit !== 66'd0) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b flit=%h, required 0/0", noc_valid, noc_flit);
    end
    @(negedge clk);
    rst = 1;
    mrr = 0; m_req = 0; m_rsp = 0; m_stall = 0;
    reqq.push_back(mk(5'd1, 0, 8'd0, 28'h0000999, '0));
    run_traffic(100, -1, 0, 100);
  endtask

  task automatic test_wrap();
`ifdef L2_NOC_TX_STATS_EN
    @(negedge clk);
    dut.req_pkt_cnt = 32'hFFFF_FFFF;
    reqq.push_back(mk(5'd1, 0, 8'd0, 28'h0000123, '0));
    run_traffic(100, -1, 0, 100);
    vectors++;
    if (stats_req_pkts !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap: stats_req_pkts %h, required 0", stats_req_pkts);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_gets();
    test_edata();
    test_alternate();
    test_back_to_back();
    test_stall();
    test_random();
    test_stats();
    test_reset_mid();
    test_stats();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
